// File: rtl/usb_packet_rx.sv
// Packet-level receive stage of the USB SIE: validates the PID, decodes token, SOF,
// handshake and DATA0/1 packets, checks CRC5/CRC16 and forwards payload bytes.
module usb_packet_rx #(
    parameter int MAX_PAYLOAD = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [7:0]                         rx_data,
    input  logic                               rx_active,
    input  logic                               rx_valid,
    input  logic                               rx_error,
    output logic [3:0]                         pid,
    output logic                               token_valid,
    output logic [6:0]                         addr,
    output logic [3:0]                         endp,
    output logic                               sof_valid,
    output logic [10:0]                        frame_no,
    output logic                               hs_valid,
    output logic [7:0]                         data_out,
    output logic                               data_strobe,
    output logic                               data_done,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]   data_len,
    output logic                               pkt_error
);

    localparam int LW = $clog2(MAX_PAYLOAD + 1);
    localparam int CW = $clog2(MAX_PAYLOAD + 3);
    localparam logic [CW-1:0] OVF_CNT = CW'(MAX_PAYLOAD + 2);

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [4:0]  CRC5_GOOD  = 5'h06;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_GOOD = 16'hB001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_TOK1,
        ST_TOK2,
        ST_DATA,
        ST_HS,
        ST_DISCARD
    } state_t;

    state_t          state;
    logic            rx_active_q;
    logic [4:0]      crc5;
    logic [15:0]     crc16;
    logic [CW-1:0]   byte_cnt;
    logic [7:0]      dly0;
    logic [7:0]      dly1;
    logic [7:0]      tok_lo;
    logic [2:0]      tok_hi;
    logic [3:0]      pid_q;

    // Bit-serial CRCs unrolled over one byte, LSB first, right-shifting register.
    function automatic logic [4:0] crc5_byte(input logic [4:0] c, input logic [7:0] b);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 5'h14;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // rx_active_q resets high so a packet already in flight during reset is never
    // mistaken for a fresh start; only a genuine rising edge enters PID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            rx_active_q <= 1'b1;
            crc5        <= CRC5_INIT;
            crc16       <= CRC16_INIT;
            byte_cnt    <= '0;
            dly0        <= '0;
            dly1        <= '0;
            tok_lo      <= '0;
            tok_hi      <= '0;
            pid_q       <= '0;
            pid         <= '0;
            token_valid <= 1'b0;
            addr        <= '0;
            endp        <= '0;
            sof_valid   <= 1'b0;
            frame_no    <= '0;
            hs_valid    <= 1'b0;
            data_out    <= '0;
            data_strobe <= 1'b0;
            data_done   <= 1'b0;
            data_len    <= '0;
            pkt_error   <= 1'b0;
        end else begin
            rx_active_q <= rx_active;
            token_valid <= 1'b0;
            sof_valid   <= 1'b0;
            hs_valid    <= 1'b0;
            data_strobe <= 1'b0;
            data_done   <= 1'b0;
            pkt_error   <= 1'b0;

            if (rx_active && !rx_active_q) begin
                state    <= ST_PID;
                crc5     <= CRC5_INIT;
                crc16    <= CRC16_INIT;
                byte_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: ;

                    ST_PID: begin
                        if (!rx_active) begin
                            pkt_error <= 1'b1;
                            state     <= ST_IDLE;
                        end else if (rx_error) begin
                            state <= ST_DISCARD;
                        end else if (rx_valid) begin
                            pid_q <= rx_data[3:0];
                            if (rx_data[7:4] != ~rx_data[3:0]) begin
                                state <= ST_DISCARD;
                            end else begin
                                case (rx_data[3:0])
                                    PID_OUT, PID_IN, PID_SETUP, PID_SOF: state <= ST_TOK1;
                                    PID_DATA0, PID_DATA1:                state <= ST_DATA;
                                    PID_ACK, PID_NAK, PID_STALL:         state <= ST_HS;
                                    default:                             state <= ST_DISCARD;
                                endcase
                            end
                        end
                    end

                    ST_TOK1: begin
                        if (!rx_active) begin
                            pkt_error <= 1'b1;
                            state     <= ST_IDLE;
                        end else if (rx_error) begin
                            state <= ST_DISCARD;
                        end else if (rx_valid) begin
                            tok_lo   <= rx_data;
                            crc5     <= crc5_byte(crc5, rx_data);
                            byte_cnt <= '0;
                            state    <= ST_TOK2;
                        end
                    end

                    // byte_cnt marks whether the second token byte has arrived;
                    // anything beyond it makes the token malformed.
                    ST_TOK2: begin
                        if (!rx_active) begin
                            state <= ST_IDLE;
                            if (byte_cnt == CW'(1) && crc5 == CRC5_GOOD) begin
                                pid <= pid_q;
                                if (pid_q == PID_SOF) begin
                                    sof_valid <= 1'b1;
                                    frame_no  <= {tok_hi, tok_lo};
                                end else begin
                                    token_valid <= 1'b1;
                                    addr        <= tok_lo[6:0];
                                    endp        <= {tok_hi, tok_lo[7]};
                                end
                            end else begin
                                pkt_error <= 1'b1;
                            end
                        end else if (rx_error) begin
                            state <= ST_DISCARD;
                        end else if (rx_valid) begin
                            if (byte_cnt == '0) begin
                                tok_hi   <= rx_data[2:0];
                                crc5     <= crc5_byte(crc5, rx_data);
                                byte_cnt <= CW'(1);
                            end else begin
                                state <= ST_DISCARD;
                            end
                        end
                    end

                    // The two newest bytes sit in dly0/dly1 so the trailing CRC16
                    // bytes are never forwarded to the endpoint buffer.
                    ST_DATA: begin
                        if (!rx_active) begin
                            state <= ST_IDLE;
                            if (byte_cnt >= CW'(2) && crc16 == CRC16_GOOD) begin
                                data_done <= 1'b1;
                                data_len  <= LW'(byte_cnt - CW'(2));
                                pid       <= pid_q;
                            end else begin
                                pkt_error <= 1'b1;
                            end
                        end else if (rx_error) begin
                            state <= ST_DISCARD;
                        end else if (rx_valid) begin
                            crc16    <= crc16_byte(crc16, rx_data);
                            dly0     <= rx_data;
                            dly1     <= dly0;
                            byte_cnt <= byte_cnt + CW'(1);
                            if (byte_cnt >= OVF_CNT) begin
                                state <= ST_DISCARD;
                            end else if (byte_cnt >= CW'(2)) begin
                                data_out    <= dly1;
                                data_strobe <= 1'b1;
                            end
                        end
                    end

                    ST_HS: begin
                        if (!rx_active) begin
                            hs_valid <= 1'b1;
                            pid      <= pid_q;
                            state    <= ST_IDLE;
                        end else if (rx_error || rx_valid) begin
                            state <= ST_DISCARD;
                        end
                    end

                    ST_DISCARD: begin
                        if (!rx_active) begin
                            pkt_error <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
